// File: rtl/vp_pkg.sv
// Shared vector-processor definitions: funct codes, ALUOp encodings,
// the ALU sequencer state encoding and the architectural vector length.
package vp_pkg;

   localparam int VLMAX = 32;

   typedef enum logic [5:0] {
      FN_NOP  = 6'h00,
      FN_SLL  = 6'h04,
      FN_SRL  = 6'h06,
      FN_MULT = 6'h18,
      FN_ADD  = 6'h20,
      FN_SUB  = 6'h22,
      FN_AND  = 6'h24,
      FN_OR   = 6'h25,
      FN_XOR  = 6'h26,
      FN_SLT  = 6'h2a,
      FN_ABS  = 6'h30
   } funct_e;

   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_RTYPE  = 2'b10
   } aluop_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_ZERO  = 2'd3
   } seq_state_e;

   // Requested lengths beyond the register size run as a full register.
   function automatic logic [5:0] clamp_vl(input logic [5:0] vl, input int vlmax);
      return (int'(vl) > vlmax) ? 6'(vlmax) : vl;
   endfunction

endpackage

// File: rtl/valu_seq.sv
// Vector ALU sequencer: streams one vector R-type instruction element by
// element through the shared scalar ALU using a read/execute/write pipeline.
module valu_seq
   import vp_pkg::*;
#(
   parameter int VLMAX = vp_pkg::VLMAX,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_valid,
   output logic          issue_ready,
   input  logic [5:0]    issue_funct,
   input  logic [5:0]    issue_vl,
   input  logic [4:0]    issue_vs1,
   input  logic [4:0]    issue_vs2,
   input  logic [4:0]    issue_vd,
   input  logic          kill,
   output logic          rf_rd_en,
   output logic [4:0]    rf_rd_vs1,
   output logic [4:0]    rf_rd_vs2,
   output logic [4:0]    cnt,
   output logic [1:0]    alu_op,
   output logic [5:0]    alu_funct,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_overflow,
   output logic          wb_en,
   output logic [4:0]    wb_vd,
   output logic [4:0]    wb_elem,
   output logic [DW-1:0] wb_data,
   output logic          done,
   output logic          ovf
);

   seq_state_e    r_state;
   aluop_e        r_alu_op;
   logic [5:0]    r_funct;
   logic [5:0]    r_vl;
   logic [4:0]    r_vs1;
   logic [4:0]    r_vs2;
   logic [4:0]    r_vd;
   logic [4:0]    r_cnt;
   logic          r_rd_en;
   logic          r_drain;
   logic          r_e_valid;
   logic          r_e_last;
   logic [4:0]    r_e_elem;
   logic          r_wb_en;
   logic [4:0]    r_wb_elem;
   logic [DW-1:0] r_wb_data;
   logic          r_done;
   logic          r_ovf;

   logic          w_accept;
   logic [5:0]    w_vl;
   logic          w_last_rd;
   logic          w_ovf_track;

   assign w_accept    = issue_valid && (r_state == S_IDLE) && !kill;
   assign w_vl        = clamp_vl(issue_vl, VLMAX);
   assign w_last_rd   = (r_cnt == 5'(r_vl - 6'd1));
   assign w_ovf_track = (r_funct == FN_ADD) || (r_funct == FN_SUB);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_alu_op  <= ALUOP_MEM;
         r_funct   <= '0;
         r_vl      <= '0;
         r_vs1     <= '0;
         r_vs2     <= '0;
         r_vd      <= '0;
         r_cnt     <= '0;
         r_rd_en   <= 1'b0;
         r_drain   <= 1'b0;
         r_e_valid <= 1'b0;
         r_e_last  <= 1'b0;
         r_e_elem  <= '0;
         r_wb_en   <= 1'b0;
         r_wb_elem <= '0;
         r_wb_data <= '0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         // Pipeline advance: R -> E -> W, every valid squashed by kill.
         r_e_valid <= r_rd_en && !kill;
         r_e_elem  <= r_cnt;
         r_e_last  <= w_last_rd;
         r_wb_en   <= r_e_valid && !kill;
         r_wb_elem <= r_e_elem;
         r_done    <= r_e_valid && r_e_last && !kill;
         if (r_e_valid) begin
            r_wb_data <= alu_result;
         end
         if (r_e_valid && w_ovf_track && !kill) begin
            r_ovf <= r_ovf | alu_overflow;
         end

         if (kill) begin
            r_state  <= S_IDLE;
            r_rd_en  <= 1'b0;
            r_alu_op <= ALUOP_MEM;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_funct  <= issue_funct;
                     r_vl     <= w_vl;
                     r_vs1    <= issue_vs1;
                     r_vs2    <= issue_vs2;
                     r_vd     <= issue_vd;
                     r_cnt    <= '0;
                     r_ovf    <= 1'b0;
                     r_alu_op <= ALUOP_RTYPE;
                     if (w_vl == 6'd0) begin
                        r_state <= S_ZERO;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_RUN;
                        r_rd_en <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  // Stop on the last index so cnt never wraps at VLMAX.
                  if (w_last_rd) begin
                     r_rd_en <= 1'b0;
                     r_drain <= 1'b0;
                     r_state <= S_DRAIN;
                  end else begin
                     r_cnt <= r_cnt + 5'd1;
                  end
               end
               S_DRAIN: begin
                  if (r_drain) begin
                     r_state  <= S_IDLE;
                     r_alu_op <= ALUOP_MEM;
                  end else begin
                     r_drain <= 1'b1;
                  end
               end
               S_ZERO: begin
                  r_state  <= S_IDLE;
                  r_alu_op <= ALUOP_MEM;
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_alu_op <= ALUOP_MEM;
               end
            endcase
         end
      end
   end

   assign issue_ready = (r_state == S_IDLE);
   assign rf_rd_en    = r_rd_en;
   assign rf_rd_vs1   = r_vs1;
   assign rf_rd_vs2   = r_vs2;
   assign cnt         = r_cnt;
   assign alu_op      = r_alu_op;
   assign alu_funct   = r_funct;
   assign wb_en       = r_wb_en && !kill;
   assign wb_vd       = r_vd;
   assign wb_elem     = r_wb_elem;
   assign wb_data     = r_wb_data;
   assign done        = r_done && !kill;
   assign ovf         = r_ovf;

endmodule

// File: tb/tb_valu_seq.sv
// Table-driven bench for valu_seq; the bench plays the parent, providing a
// register file with 1-cycle read and a scalar ALU stand-in.
module tb_valu_seq;
   import vp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        issue_ready;
   logic [5:0]  issue_funct;
   logic [5:0]  issue_vl;
   logic [4:0]  issue_vs1, issue_vs2, issue_vd;
   logic        kill;
   logic        rf_rd_en;
   logic [4:0]  rf_rd_vs1, rf_rd_vs2, cnt;
   logic [1:0]  alu_op;
   logic [5:0]  alu_funct;
   logic [31:0] alu_result;
   logic        alu_overflow;
   logic        wb_en;
   logic [4:0]  wb_vd, wb_elem;
   logic [31:0] wb_data;
   logic        done;
   logic        ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   valu_seq dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_funct(issue_funct), .issue_vl(issue_vl),
      .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vd(issue_vd),
      .kill(kill),
      .rf_rd_en(rf_rd_en), .rf_rd_vs1(rf_rd_vs1), .rf_rd_vs2(rf_rd_vs2),
      .cnt(cnt), .alu_op(alu_op), .alu_funct(alu_funct),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .wb_en(wb_en), .wb_vd(wb_vd), .wb_elem(wb_elem), .wb_data(wb_data),
      .done(done), .ovf(ovf)
   );

   // Register file model: synchronous read into the E-stage operands.
   logic [31:0] vrf [32][32];
   logic [31:0] rd_a, rd_b;

   always @(posedge clk) begin
      if (rf_rd_en) begin
         rd_a <= vrf[rf_rd_vs1][cnt];
         rd_b <= vrf[rf_rd_vs2][cnt];
      end
   end

   // ALU stand-in reports adder overflow for every non-SUB funct.
   always_comb begin
      logic [31:0] sum, dif;
      sum = rd_a + rd_b;
      dif = rd_a - rd_b;
      alu_result   = sum;
      alu_overflow = (rd_a[31] == rd_b[31]) && (sum[31] != rd_a[31]);
      case (alu_funct)
         FN_SUB: begin
            alu_result   = dif;
            alu_overflow = (rd_a[31] != rd_b[31]) && (dif[31] != rd_a[31]);
         end
         FN_AND:  alu_result = rd_a & rd_b;
         FN_OR:   alu_result = rd_a | rd_b;
         FN_XOR:  alu_result = rd_a ^ rd_b;
         default: alu_result = sum;
      endcase
   end

   typedef struct {
      logic [5:0]       funct;
      logic [5:0]       vl;
      logic [4:0]       vs1, vs2, vd;
      int               kill_cyc;
      int               exp_reads;
      int               exp_writes;
      int               exp_done;
      int               exp_ready;
      logic             exp_ovf;
      logic [3:0][31:0] exp_d;
      logic [31:0]      exp_last;
   } vec_t;

   vec_t tbl [8];

   function automatic vec_t mk(input logic [5:0] f, input logic [5:0] vl,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                               input int kc, input int rds, input int wrs, input int dn,
                               input int rdy, input logic ov,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input logic [31:0] last);
      vec_t v;
      v.funct = f; v.vl = vl; v.vs1 = s1; v.vs2 = s2; v.vd = d;
      v.kill_cyc = kc; v.exp_reads = rds; v.exp_writes = wrs;
      v.exp_done = dn; v.exp_ready = rdy; v.exp_ovf = ov;
      v.exp_d[0] = d0; v.exp_d[1] = d1; v.exp_d[2] = d2; v.exp_d[3] = d3;
      v.exp_last = last;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},   32'(issue_ready), 32'd1);
      check({tag, "_rd_en"},   32'(rf_rd_en),    32'd0);
      check({tag, "_cnt"},     32'(cnt),         32'd0);
      check({tag, "_alu_op"},  32'(alu_op),      32'd0);
      check({tag, "_funct"},   32'(alu_funct),   32'd0);
      check({tag, "_wb_en"},   32'(wb_en),       32'd0);
      check({tag, "_wb_vd"},   32'(wb_vd),       32'd0);
      check({tag, "_wb_elem"}, 32'(wb_elem),     32'd0);
      check({tag, "_wb_data"}, wb_data,          32'd0);
      check({tag, "_done"},    32'(done),        32'd0);
      check({tag, "_ovf"},     32'(ovf),         32'd0);
   endtask

   // Issue one instruction (cycle 0 = accept) and observe until issue_ready returns.
   task automatic run_vec(input vec_t v, input string tag);
      int cyc = 0, reads = 0, writes = 0, done_cyc = 0, done_n = 0, ready_cyc = 0;
      int rd_err = 0, el_err = 0, vd_err = 0;
      logic ovf_done = 1'b0, ovf_ready = 1'b0;
      logic [31:0] data [32];
      for (int i = 0; i < 32; i++) data[i] = '0;
      issue_valid = 1'b1; issue_funct = v.funct; issue_vl = v.vl;
      issue_vs1 = v.vs1; issue_vs2 = v.vs2; issue_vd = v.vd;
      @(posedge clk);
      while (ready_cyc == 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         issue_valid = 1'b0;
         kill = (cyc == v.kill_cyc);
         #1;
         if (rf_rd_en) begin
            if (cnt != 5'(reads)) rd_err++;
            reads++;
         end
         if (wb_en) begin
            if (wb_elem != 5'(writes)) el_err++;
            if (wb_vd != v.vd) vd_err++;
            if (writes < 32) data[writes] = wb_data;
            writes++;
         end
         if (done) begin done_n++; done_cyc = cyc; ovf_done = ovf; end
         if (issue_ready) begin ready_cyc = cyc; ovf_ready = ovf; end
      end
      kill = 1'b0;
      if (ready_cyc == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
      check({tag, "_reads"},     32'(reads),     32'(v.exp_reads));
      check({tag, "_rd_order"},  32'(rd_err),    32'd0);
      check({tag, "_writes"},    32'(writes),    32'(v.exp_writes));
      check({tag, "_elem_ord"},  32'(el_err),    32'd0);
      check({tag, "_wb_vd"},     32'(vd_err),    32'd0);
      check({tag, "_done_n"},    32'(done_n),    (v.exp_done != 0) ? 32'd1 : 32'd0);
      check({tag, "_done_cyc"},  32'(done_cyc),  32'(v.exp_done));
      check({tag, "_ready_cyc"}, 32'(ready_cyc), 32'(v.exp_ready));
      check({tag, "_ovf_end"},   32'(ovf_ready), 32'(v.exp_ovf));
      if (v.exp_done != 0) check({tag, "_ovf_done"}, 32'(ovf_done), 32'(v.exp_ovf));
      for (int i = 0; i < 4; i++)
         if (i < v.exp_writes) check($sformatf("%s_data%0d", tag, i), data[i], v.exp_d[i]);
      if (v.exp_writes > 0) check({tag, "_last"}, data[v.exp_writes-1], v.exp_last);
      $display("%s: funct=%02h vl=%0d reads=%0d writes=%0d done@%0d ready@%0d ovf=%0b",
               tag, v.funct, v.vl, reads, writes, done_cyc, ready_cyc, ovf_ready);
   endtask

   initial begin
      for (int r = 0; r < 32; r++)
         for (int e = 0; e < 32; e++) vrf[r][e] = '0;
      for (int e = 0; e < 32; e++) begin
         vrf[1][e] = 32'(e + 1);
         vrf[2][e] = 32'(10 * (e + 1));
      end
      vrf[3][0] = 32'd5; vrf[3][1] = 32'h8000_0000;
      vrf[4][0] = 32'd3; vrf[4][1] = 32'd1;

      //           funct   vl  s1 s2 vd kill rds wrs done rdy ovf  d0  d1            d2  d3  last
      tbl[0] = mk(FN_ADD, 4,  1, 2, 5,  0,  4,  4,  6,  7, 0, 11, 22,           33, 44, 44);
      tbl[1] = mk(FN_SUB, 2,  3, 4, 6,  0,  2,  2,  4,  5, 1, 2,  32'h7fffffff, 0,  0,  32'h7fffffff);
      tbl[2] = mk(FN_ADD, 0,  1, 2, 5,  0,  0,  0,  1,  2, 0, 0,  0,            0,  0,  0);
      tbl[3] = mk(FN_ADD, 32, 1, 2, 8,  0,  32, 32, 34, 35, 0, 11, 22,          33, 44, 352);
      tbl[4] = mk(FN_ADD, 40, 1, 2, 9,  0,  32, 32, 34, 35, 0, 11, 22,          33, 44, 352);
      tbl[5] = mk(FN_ADD, 8,  1, 2, 10, 3,  3,  0,  0,  4, 0, 0,  0,            0,  0,  0);
      tbl[6] = mk(FN_XOR, 2,  3, 3, 11, 0,  2,  2,  4,  5, 0, 0,  0,            0,  0,  0);
      tbl[7] = mk(FN_ADD, 2,  3, 3, 12, 0,  2,  2,  4,  5, 1, 10, 0,            0,  0,  0);

      rst = 1'b1; kill = 1'b0; issue_valid = 1'b0;
      issue_funct = '0; issue_vl = '0; issue_vs1 = '0; issue_vs2 = '0; issue_vd = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int k = 0; k < 8; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

      // Issue coincident with kill must not be accepted.
      issue_valid = 1'b1; kill = 1'b1; issue_funct = FN_ADD; issue_vl = 6'd4;
      issue_vs1 = 5'd1; issue_vs2 = 5'd2; issue_vd = 5'd5;
      @(posedge clk);
      @(negedge clk);
      issue_valid = 1'b0; kill = 1'b0;
      #1;
      check("killissue_ready", 32'(issue_ready), 32'd1);
      check("killissue_rd_en", 32'(rf_rd_en),    32'd0);
      check("killissue_alu_op", 32'(alu_op),     32'd0);
      $display("killissue: ready=%0b rd_en=%0b alu_op=%0d", issue_ready, rf_rd_en, alu_op);

      // Asynchronous reset in the middle of a run, then a clean instruction.
      issue_valid = 1'b1; issue_funct = FN_ADD; issue_vl = 6'd8;
      issue_vs1 = 5'd1; issue_vs2 = 5'd2; issue_vd = 5'd7;
      @(posedge clk);
      @(negedge clk); issue_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      $display("midrst: ready=%0b wb_en=%0b done=%0b wb_data=%08h", issue_ready, wb_en, done, wb_data);
      @(negedge clk);
      rst = 1'b0;
      #1;
      run_vec(tbl[0], "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
